// File: rtl/npc_pc_unit_if.sv
// -----------------------------------------------------------------------------
// npc_pc_unit_if
//
// Instruction-fetch request port of the program-counter unit. The PC unit
// drives a fetch address with a valid flag. The fetch side accepts the
// address with ready.
//
// Signals:
//   pc_o      XLEN  current fetch PC (driven by the PC unit)
//   if_valid  1     pc_o is a valid fetch request
//   if_ready  1     fetch side accepts pc_o this cycle
//
// Modports:
//   master  PC unit side  (drives pc_o / if_valid, samples if_ready)
//   slave   fetch side    (samples pc_o / if_valid, drives if_ready)
// -----------------------------------------------------------------------------
interface npc_pc_unit_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] pc_o;
    logic            if_valid;
    logic            if_ready;

    modport master (output pc_o, output if_valid, input if_ready);
    modport slave  (input pc_o, input if_valid, output if_ready);
endinterface

// File: rtl/npc_pc_unit.sv
// -----------------------------------------------------------------------------
// npc_pc_unit
//
// Program-counter unit for the single-issue core. The unit holds the
// architectural PC. It selects the next PC from one of these sources:
//   - sequential (pc+4)
//   - branch
//   - jump-register
//   - trap
//   - trap-return
// It presents the PC to instruction fetch under a valid/ready handshake.
// A redirect that arrives while fetch cannot advance is captured. The
// captured redirect is applied on the next advance. A BOOT/RUN/HALT state
// machine gates the fetch port.
//
// Parameters:
//   XLEN      PC / target width (>= 16, even)
//   RESET_PC  PC loaded at reset (truncated to XLEN)
//   TRAP_VEC  trap-entry target (truncated to XLEN)
//
// Ports:
//   clk            clock, rising edge
//   rstn           asynchronous active-low reset
//   npc_sel[2:0]   next-PC source:
//                    000 pc+4
//                    001 pc+br_off
//                    010 jr
//                    011 trap
//                    100 epc
//   redirect       npc_sel is meaningful this cycle
//   br_off         signed branch offset, relative to pc_o
//   jr_base/jr_off jump-register operands
//   epc            trap-return address
//   stall          pipeline hold; the PC must not advance
//   halt_req       level request to stop fetch
//   resume         pulse; leave HALT
//   fetch          fetch port (pc_o, if_valid out; if_ready in)
//   redirect_pend  a captured redirect awaits application
//   sel_err        one-cycle pulse after a reserved npc_sel with redirect=1
//   halted         the state machine is in HALT
//
// Build option NPC_MISALIGN_TRAP_EN:
//   Defined:
//     A non-trap redirect target with bits[1:0] != 0 is replaced by
//     TRAP_VEC. Two extra ports are present:
//       misalign  registered pulse
//       bad_addr  last offending target
//   Undefined:
//     Redirect targets have bits[1:0] forced to 00.
// -----------------------------------------------------------------------------
module npc_pc_unit #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [2:0]      npc_sel,
    input  logic            redirect,
    input  logic [XLEN-1:0] br_off,
    input  logic [XLEN-1:0] jr_base,
    input  logic [XLEN-1:0] jr_off,
    input  logic [XLEN-1:0] epc,
    input  logic            stall,
    input  logic            halt_req,
    input  logic            resume,
    npc_pc_unit_if.master   fetch,
    output logic            redirect_pend,
    output logic            sel_err,
    output logic            halted
`ifdef NPC_MISALIGN_TRAP_EN
    ,
    output logic            misalign,
    output logic [XLEN-1:0] bad_addr
`endif
);

    localparam logic [XLEN-1:0] RESET_PC_X = XLEN'(RESET_PC);
    localparam logic [XLEN-1:0] TRAP_VEC_X = XLEN'(TRAP_VEC);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] BIT0_MASK  = ~(XLEN'(1));
`ifndef NPC_MISALIGN_TRAP_EN
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));
`endif

    localparam logic [2:0] SEL_SEQ  = 3'b000;
    localparam logic [2:0] SEL_BR   = 3'b001;
    localparam logic [2:0] SEL_JR   = 3'b010;
    localparam logic [2:0] SEL_TRAP = 3'b011;
    localparam logic [2:0] SEL_EPC  = 3'b100;

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    logic [1:0]      state_q;
    logic [1:0]      state_nxt;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] pend_pc_q;
    logic            pend_trap_q;
    logic            if_valid_q;
    logic            adv;

    logic [XLEN-1:0] jr_sum;
    logic [XLEN-1:0] raw_tgt;
    logic [XLEN-1:0] new_tgt;
    logic [XLEN-1:0] eff_tgt;
    logic            sel_ok;
    logic            sel_rsvd;
    logic            req_trap;
    logic            new_trap;
    logic            take_new;
    logic            eff_pend;
    logic            eff_trap;
`ifdef NPC_MISALIGN_TRAP_EN
    logic            mis_hit;
`endif

    assign fetch.pc_o     = pc_q;
    assign fetch.if_valid = if_valid_q;

    assign adv    = if_valid_q & fetch.if_ready & ~stall;
    assign pc_inc = pc_q + PC_STEP;
    assign jr_sum = jr_base + jr_off;

    // Raw redirect target and decode of npc_sel.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        raw_tgt  = pc_inc;
        sel_ok   = 1'b0;
        sel_rsvd = 1'b0;
        req_trap = 1'b0;
        case (npc_sel)
            SEL_SEQ: sel_ok = 1'b0;
            SEL_BR: begin
                raw_tgt = pc_q + br_off;
                sel_ok  = 1'b1;
            end
            SEL_JR: begin
                raw_tgt = jr_sum & BIT0_MASK;
                sel_ok  = 1'b1;
            end
            SEL_TRAP: begin
                raw_tgt  = TRAP_VEC_X;
                sel_ok   = 1'b1;
                req_trap = 1'b1;
            end
            SEL_EPC: begin
                raw_tgt = epc;
                sel_ok  = 1'b1;
            end
            default: sel_rsvd = 1'b1;
        endcase
    end

`ifdef NPC_MISALIGN_TRAP_EN
    // A misaligned non-trap target becomes a trap entry. It therefore also
    // takes trap priority over later redirects.
    assign mis_hit  = redirect & sel_ok & ~req_trap & (raw_tgt[1:0] != 2'b00);
    assign new_tgt  = mis_hit ? TRAP_VEC_X : raw_tgt;
    assign new_trap = req_trap | mis_hit;
`else
    assign new_tgt  = raw_tgt & ALIGN_MASK;
    assign new_trap = req_trap;
`endif

    // Merge the incoming redirect with any pending one. The newer redirect
    // wins, except that a pending trap is never displaced by a non-trap
    // redirect. The merged view is what an advance in this cycle applies.
    // This also covers a redirect in the same cycle as the advance.
    assign take_new = redirect & sel_ok & (new_trap | ~pend_trap_q);
    assign eff_pend = take_new | redirect_pend;
    assign eff_tgt  = take_new ? new_tgt  : pend_pc_q;
    assign eff_trap = take_new ? new_trap : pend_trap_q;

    // Halt control. In RUN, if_valid is high, so a halt waits for the current
    // request to be accepted. resume takes precedence over halt_req in HALT.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_BOOT: state_nxt = S_RUN;
            S_RUN:  if (halt_req && adv) state_nxt = S_HALT;
            S_HALT: if (resume) state_nxt = S_RUN;
            default: state_nxt = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_BOOT;
            if_valid_q    <= 1'b0;
            halted        <= 1'b0;
            sel_err       <= 1'b0;
            pc_q          <= RESET_PC_X;
            pend_pc_q     <= RESET_PC_X;
            pend_trap_q   <= 1'b0;
            redirect_pend <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // flop samples pre-edge values regardless of statement order.
            state_q    <= state_nxt;
            if_valid_q <= (state_nxt == S_RUN);
            halted     <= (state_nxt == S_HALT);
            sel_err    <= redirect & sel_rsvd;
            pend_pc_q  <= eff_tgt;
            if (adv) begin
                pc_q          <= eff_pend ? eff_tgt : pc_inc;
                redirect_pend <= 1'b0;
                pend_trap_q   <= 1'b0;
            end else begin
                redirect_pend <= eff_pend;
                pend_trap_q   <= eff_trap;
            end
        end
    end

`ifdef NPC_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            misalign <= 1'b0;
            bad_addr <= '0;
        end else begin
            misalign <= mis_hit;
            if (mis_hit) begin
                bad_addr <= raw_tgt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_npc_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_npc_pc_unit
//
// Directed bench for npc_pc_unit, built with XLEN=32, RESET_PC=0x34 and
// TRAP_VEC=0x100.
//
// Checking is split across two processes:
//   - Stimulus process: pushes the expected fetch address of every
//     handshake into a queue.
//   - Monitor process: pops from that queue and compares each time the DUT
//     fetch port completes a handshake.
// Point checks cover reset values, pending/halt flags and the sel_err pulse.
// -----------------------------------------------------------------------------
module tb_npc_pc_unit;

    localparam int          XLEN   = 32;
    localparam logic [31:0] RST_PC = 32'h0000_0034;
    localparam logic [31:0] TRAP   = 32'h0000_0100;

    logic            clk;
    logic            rstn;
    logic [2:0]      npc_sel;
    logic            redirect;
    logic [XLEN-1:0] br_off;
    logic [XLEN-1:0] jr_base;
    logic [XLEN-1:0] jr_off;
    logic [XLEN-1:0] epc;
    logic            stall;
    logic            halt_req;
    logic            resume;
    logic            redirect_pend;
    logic            sel_err;
    logic            halted;
`ifdef NPC_MISALIGN_TRAP_EN
    logic            misalign;
    logic [XLEN-1:0] bad_addr;
`endif

    npc_pc_unit_if #(.XLEN(XLEN)) fetch_if ();

    npc_pc_unit #(
        .XLEN     (XLEN),
        .RESET_PC (RST_PC),
        .TRAP_VEC (TRAP)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .npc_sel       (npc_sel),
        .redirect      (redirect),
        .br_off        (br_off),
        .jr_base       (jr_base),
        .jr_off        (jr_off),
        .epc           (epc),
        .stall         (stall),
        .halt_req      (halt_req),
        .resume        (resume),
        .fetch         (fetch_if),
        .redirect_pend (redirect_pend),
        .sel_err       (sel_err),
        .halted        (halted)
`ifdef NPC_MISALIGN_TRAP_EN
        ,
        .misalign      (misalign),
        .bad_addr      (bad_addr)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [XLEN-1:0] exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every accepted fetch must match the next expected PC.
    always @(negedge clk) begin
        if (rstn && fetch_if.if_valid && fetch_if.if_ready && !stall) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL fetch_extra: got pc %h, expected no fetch", fetch_if.pc_o);
            end else begin
                check("fetch_pc", fetch_if.pc_o, exp_q.pop_front());
            end
        end
    end

    initial begin
        rstn     = 1'b0;
        npc_sel  = 3'b000;
        redirect = 1'b0;
        br_off   = '0;
        jr_base  = '0;
        jr_off   = '0;
        epc      = '0;
        stall    = 1'b0;
        halt_req = 1'b0;
        resume   = 1'b0;
        fetch_if.if_ready = 1'b0;
        repeat (3) tick();

        check("rst_pc", fetch_if.pc_o, RST_PC);
        check("rst_valid", fetch_if.if_valid, 1'b0);
        check("rst_pend", redirect_pend, 1'b0);
        check("rst_sel_err", sel_err, 1'b0);
        check("rst_halted", halted, 1'b0);
`ifdef NPC_MISALIGN_TRAP_EN
        check("rst_misalign", misalign, 1'b0);
        check("rst_bad_addr", bad_addr, 32'h0);
`endif

        // Boot and sequential fetch, then a branch at 0x40 with br_off=-8.
        exp_q.push_back(32'h34);
        exp_q.push_back(32'h38);
        exp_q.push_back(32'h3C);
        exp_q.push_back(32'h40);
        exp_q.push_back(32'h38);
        fetch_if.if_ready = 1'b1;
        rstn = 1'b1;
        check("boot_valid", fetch_if.if_valid, 1'b0);
        tick();
        check("first_valid", fetch_if.if_valid, 1'b1);
        check("first_pc", fetch_if.pc_o, RST_PC);
        tick();
        tick();
        tick();
        check("pc_at_branch", fetch_if.pc_o, 32'h40);
        redirect = 1'b1;
        npc_sel  = 3'b001;
        br_off   = 32'hFFFF_FFF8;
        tick();
        redirect = 1'b0;
        check("br_pc", fetch_if.pc_o, 32'h38);
        check("br_no_pend", redirect_pend, 1'b0);

        // Stall for three cycles. A jr redirect is captured, then it is
        // overwritten by an epc redirect.
        exp_q.push_back(32'h3C);
        exp_q.push_back(32'h200);
        tick();
        stall    = 1'b1;
        redirect = 1'b1;
        npc_sel  = 3'b010;
        jr_base  = 32'h1001;
        jr_off   = 32'h10;
        tick();
        npc_sel  = 3'b100;
        epc      = 32'h200;
        check("stall_pend_jr", redirect_pend, 1'b1);
        check("stall_hold_pc", fetch_if.pc_o, 32'h3C);
        tick();
        redirect = 1'b0;
        check("stall_pend_epc", redirect_pend, 1'b1);
        tick();
        stall = 1'b0;
        check("stall_pend_keep", redirect_pend, 1'b1);
        tick();
        check("epc_pc", fetch_if.pc_o, 32'h200);
        check("epc_pend_clr", redirect_pend, 1'b0);

        // A pending trap must not be overwritten by a later branch while
        // fetch is not ready.
        exp_q.push_back(32'h204);
        exp_q.push_back(TRAP);
        tick();
        fetch_if.if_ready = 1'b0;
        redirect = 1'b1;
        npc_sel  = 3'b011;
        tick();
        npc_sel  = 3'b001;
        br_off   = 32'h80;
        check("trap_pend", redirect_pend, 1'b1);
        tick();
        redirect = 1'b0;
        fetch_if.if_ready = 1'b1;
        check("trap_pend_keep", redirect_pend, 1'b1);
        tick();
        check("trap_pc", fetch_if.pc_o, TRAP);

        // A reserved select pulses sel_err. The PC keeps stepping by 4.
        exp_q.push_back(32'h104);
        exp_q.push_back(32'h108);
        redirect = 1'b1;
        npc_sel  = 3'b110;
        tick();
        redirect = 1'b0;
        check("sel_err_pulse", sel_err, 1'b1);
        check("sel_err_no_pend", redirect_pend, 1'b0);
        tick();
        check("sel_err_clear", sel_err, 1'b0);
        check("sel_err_pc", fetch_if.pc_o, 32'h108);

        // Halt after the accepted fetch of 0x108. The resume cycle also has
        // halt_req high, and fetch restarts at 0x10C.
        exp_q.push_back(32'h10C);
        exp_q.push_back(32'h110);
        exp_q.push_back(32'h300);
        halt_req = 1'b1;
        tick();
        check("halt_halted", halted, 1'b1);
        check("halt_valid", fetch_if.if_valid, 1'b0);
        check("halt_pc", fetch_if.pc_o, 32'h10C);
        tick();
        resume = 1'b1;
        check("halt_hold", halted, 1'b1);
        tick();
        resume = 1'b0;
        check("resume_halted", halted, 1'b0);
        check("resume_valid", fetch_if.if_valid, 1'b1);
        check("resume_pc", fetch_if.pc_o, 32'h10C);

        // Halt again. A redirect made during HALT is applied on resume.
        tick();
        halt_req = 1'b0;
        check("halt2_halted", halted, 1'b1);
        redirect = 1'b1;
        npc_sel  = 3'b100;
        epc      = 32'h300;
        tick();
        redirect = 1'b0;
        resume   = 1'b1;
        check("halt2_pend", redirect_pend, 1'b1);
        tick();
        resume = 1'b0;
        check("halt2_valid", fetch_if.if_valid, 1'b1);
        check("halt2_pc", fetch_if.pc_o, 32'h110);
        tick();
        check("halt2_target", fetch_if.pc_o, 32'h300);

        // Branch to a misaligned target, followed by a jr whose bit 0 is cleared.
        redirect = 1'b1;
        npc_sel  = 3'b001;
        br_off   = 32'h6;
`ifdef NPC_MISALIGN_TRAP_EN
        exp_q.push_back(TRAP);
`else
        exp_q.push_back(32'h304);
`endif
        exp_q.push_back(32'h1010);
        tick();
        npc_sel = 3'b010;
        jr_base = 32'h1001;
        jr_off  = 32'h10;
`ifdef NPC_MISALIGN_TRAP_EN
        check("mis_pc", fetch_if.pc_o, TRAP);
        check("mis_pulse", misalign, 1'b1);
        check("mis_bad_addr", bad_addr, 32'h306);
`else
        check("align_pc", fetch_if.pc_o, 32'h304);
`endif
        tick();
        redirect = 1'b0;
        check("jr_pc", fetch_if.pc_o, 32'h1010);
`ifdef NPC_MISALIGN_TRAP_EN
        check("mis_pulse_end", misalign, 1'b0);
        check("mis_bad_hold", bad_addr, 32'h306);
`endif

        // A reset asserted mid-operation drops a pending redirect at once.
        tick();
        fetch_if.if_ready = 1'b0;
        redirect = 1'b1;
        npc_sel  = 3'b100;
        epc      = 32'h500;
        tick();
        redirect = 1'b0;
        check("pre_rst_pend", redirect_pend, 1'b1);
        rstn = 1'b0;
        #1;
        check("mid_rst_pend", redirect_pend, 1'b0);
        check("mid_rst_pc", fetch_if.pc_o, RST_PC);
        check("mid_rst_valid", fetch_if.if_valid, 1'b0);
        exp_q.push_back(32'h34);
        exp_q.push_back(32'h38);
        tick();
        tick();
        fetch_if.if_ready = 1'b1;
        rstn = 1'b1;
        tick();
        tick();
        tick();
        fetch_if.if_ready = 1'b0;
        check("post_rst_pc", fetch_if.pc_o, 32'h3C);

        check("queue_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
